sync_fifo_flags: RTL

SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_dpram.sv | 26 ++
 rtl/sync_fifo_flags.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and elaboration helpers for the synchronous FIFO family.
package fifo_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 16;

    // Ceiling log2, used to cross-check the pointer width against the depth.
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 32'd0;
        remain = value - 32'd1;
        while (remain > 32'd0) begin
            result = result + 32'd1;
            remain = remain >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_dpram.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// Contents are never reset; the pointer logic decides what is valid.
module fifo_dpram #(
    parameter int WIDTH     = 8,
    parameter int PTR_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [PTR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [PTR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [0:(2**PTR_WIDTH)-1];

    // Store an accepted write at the write address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with occupancy count, high-water mark, almost/full/empty
// flags and one-cycle overflow/underflow error pulses. Supports a standard
// registered read or first-word-fall-through presentation of the head entry.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int PTR_WIDTH = 4,
    parameter int AF_LEVEL  = DEPTH - 2,
    parameter int AE_LEVEL  = 2,
    parameter int FWFT      = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               wr_en,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               rd_en,
    output logic [WIDTH-1:0]   rd_data,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic               almost_empty,
    output logic               wr_error,
    output logic               rd_error,
    output logic [PTR_WIDTH:0] count,
    output logic [PTR_WIDTH:0] max_count
);

    // Reject configurations where the address width cannot index DEPTH entries.
    if ((PTR_WIDTH != clog2(DEPTH)) || (DEPTH < 4) || ((1 << PTR_WIDTH) != DEPTH)) begin : g_bad_cfg
        $error("sync_fifo_flags: DEPTH must be a power of two >= 4 and PTR_WIDTH = log2(DEPTH)");
    end

    localparam logic [PTR_WIDTH:0] ONE       = {{PTR_WIDTH{1'b0}}, 1'b1};
    localparam logic [PTR_WIDTH:0] ZERO      = {(PTR_WIDTH+1){1'b0}};
    localparam logic [PTR_WIDTH:0] DEPTH_CNT = DEPTH[PTR_WIDTH:0];
    localparam logic [PTR_WIDTH:0] AF_CNT    = AF_LEVEL[PTR_WIDTH:0];
    localparam logic [PTR_WIDTH:0] AE_CNT    = AE_LEVEL[PTR_WIDTH:0];

    // Registered state (pointers carry a wrap bit above the address bits).
    logic [PTR_WIDTH:0] wr_ptr;
    logic [PTR_WIDTH:0] rd_ptr;
    logic [WIDTH-1:0]   rd_data_q;

    // Next-state values.
    logic               rd_acc;
    logic               wr_acc;
    logic               mem_we;
    logic [PTR_WIDTH:0] wr_ptr_next;
    logic [PTR_WIDTH:0] rd_ptr_next;
    logic [PTR_WIDTH:0] count_next;
    logic [PTR_WIDTH:0] max_count_next;
    logic               wr_error_next;
    logic               rd_error_next;
    logic [WIDTH-1:0]   rd_data_next;
    logic               full_next;
    logic               empty_next;
    logic               almost_full_next;
    logic               almost_empty_next;

    logic [WIDTH-1:0]   mem_rdata;

    fifo_dpram #(
        .WIDTH     (WIDTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr[PTR_WIDTH-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr[PTR_WIDTH-1:0]),
        .rdata (mem_rdata)
    );

    // Accept logic, pointer/count/max update, error detection and flag lookahead.
    always_comb begin
        rd_acc            = rd_en & ~empty;
        wr_acc            = wr_en & (~full | rd_acc);
        mem_we            = 1'b0;
        wr_ptr_next       = wr_ptr;
        rd_ptr_next       = rd_ptr;
        count_next        = count;
        max_count_next    = max_count;
        wr_error_next     = 1'b0;
        rd_error_next     = 1'b0;
        rd_data_next      = rd_data_q;

        if (clr) begin
            // Flush wins over any request in the same cycle and raises no error.
            wr_ptr_next    = ZERO;
            rd_ptr_next    = ZERO;
            count_next     = ZERO;
            max_count_next = ZERO;
        end else begin
            mem_we = wr_acc;
            if (wr_acc) begin
                wr_ptr_next = wr_ptr + ONE;
            end else begin
                wr_ptr_next = wr_ptr;
            end
            if (rd_acc) begin
                rd_ptr_next  = rd_ptr + ONE;
                rd_data_next = mem_rdata;
            end else begin
                rd_ptr_next  = rd_ptr;
                rd_data_next = rd_data_q;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_next = count + ONE;
                2'b01:   count_next = count - ONE;
                default: count_next = count;
            endcase
            if (count_next > max_count) begin
                max_count_next = count_next;
            end else begin
                max_count_next = max_count;
            end
            wr_error_next = wr_en & ~wr_acc;
            rd_error_next = rd_en & empty;
        end

        full_next         = (count_next == DEPTH_CNT);
        empty_next        = (count_next == ZERO);
        almost_full_next  = (count_next >= AF_CNT);
        almost_empty_next = (count_next <= AE_CNT);
    end

    // State register; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= ZERO;
            rd_ptr       <= ZERO;
            count        <= ZERO;
            max_count    <= ZERO;
            rd_data_q    <= {WIDTH{1'b0}};
            wr_error     <= 1'b0;
            rd_error     <= 1'b0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            wr_ptr       <= wr_ptr_next;
            rd_ptr       <= rd_ptr_next;
            count        <= count_next;
            max_count    <= max_count_next;
            rd_data_q    <= rd_data_next;
            wr_error     <= wr_error_next;
            rd_error     <= rd_error_next;
            full         <= full_next;
            empty        <= empty_next;
            almost_full  <= almost_full_next;
            almost_empty <= almost_empty_next;
        end
    end

    // In fall-through mode the head entry is shown directly; it reads as zero while empty.
    assign rd_data = (FWFT != 0) ? (empty ? {WIDTH{1'b0}} : mem_rdata) : rd_data_q;

endmodule
